// File: rtl/addsub_accumulator_pkg.sv
// Shared definitions for the add/subtract accumulator front-end.
package addsub_accumulator_pkg;

    // Datapath width of the Adder_Subtractor core; only 6 is supported.
    localparam int unsigned DEF_WIDTH = 6;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_ADD   = 2'b01,
        CMD_SUB   = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Two's-complement overflow from operand/result sign bits.
    // ADD overflows when operand signs agree, SUB when they differ,
    // and in both cases only if the result sign differs from A's sign.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic sub);
        return (((a_msb ^ b_msb) == sub) && (r_msb != a_msb));
    endfunction

endpackage

// File: rtl/addsub_accumulator_core.sv
// Adder_Subtractor combinational core: ANSWER = S ? A - B : A + B (modulo 2^WIDTH).
module Adder_Subtractor
    import addsub_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] ANSWER
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] carry_in;

    // Subtraction is A + ~B + 1.
    assign b_eff    = B ^ {WIDTH{S}};
    assign carry_in = {{(WIDTH-1){1'b0}}, S};
    assign ANSWER   = A + b_eff + carry_in;

endmodule

// File: rtl/addsub_accumulator.sv
// Sequential front-end: accepts LOAD/ADD/SUB/CLEAR commands, drives the
// Adder_Subtractor from registers and emits the updated accumulator.
module addsub_accumulator
    import addsub_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_cmd,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [WIDTH-1:0] acc
);

    state_t           state, state_nxt;
    cmd_t             op_cmd;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] core_answer;
    logic [WIDTH-1:0] result;
    logic             core_sub;
    logic             result_ovf;
    logic             rdy_en;
    logic             accept;

    Adder_Subtractor #(.WIDTH(WIDTH)) u_core (
        .A      (op_a),
        .B      (op_b),
        .S      (core_sub),
        .ANSWER (core_answer)
    );

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_nxt = in_valid ? ST_EXEC : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs and core/result selection.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        core_sub   = (op_cmd == CMD_SUB);
        result     = core_answer;
        result_ovf = 1'b0;
        case (state)
            ST_IDLE: in_ready = rdy_en;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = rdy_en && out_ready;
            end
            default: ;
        endcase
        case (op_cmd)
            CMD_LOAD:  result = op_b;
            CMD_CLEAR: result = '0;
            default: begin
                result     = core_answer;
                result_ovf = ovf_calc(op_a[WIDTH-1], op_b[WIDTH-1],
                                      core_answer[WIDTH-1], core_sub);
            end
        endcase
    end

    // Operand capture, accumulator and registered result/flags.
    // rdy_en holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_cmd   <= CMD_LOAD;
            acc      <= '0;
            out_data <= '0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                op_a   <= acc;
                op_b   <= in_data;
                op_cmd <= cmd_t'(in_cmd);
            end
            if (state == ST_EXEC) begin
                acc      <= result;
                out_data <= result;
                out_zero <= (result == '0);
                out_ovf  <= result_ovf;
            end
        end
    end

endmodule
